logic_unit_pipe: RTL and testbench
==================================

// Module: logic_unit_pipe
// PURPOSE
//  Parametrised, pipelined bitwise logic unit for the ALU datapath, alongside the mux/add/sub/compare blocks.
//  Six bitwise ops on WIDTH-bit operands, plus two multi-beat accumulate ops (AND/OR reduction over a burst).
//  Valid/ready handshake on input and output. Two register stages. Full backpressure support.
// PARAMETERS
//  WIDTH   8  operand/result width in bits (>=1)
//  CNT_W   4  width of the beat counter; saturates at 2**CNT_W-1
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      input beat valid
//  in_ready   out  1      unit accepts beat this cycle
//  op         in   3      opcode (see BEHAVIOUR)
//  A          in   WIDTH  operand A
//  B          in   WIDTH  operand B
//  in_last    in   1      final beat of accumulate burst; ignored by non-acc ops
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  Y          out  WIDTH  result
//  zero       out  1      Y == 0
//  out_count  out  CNT_W  beats combined into Y (1 for non-acc ops)
// BEHAVIOUR
//  Reset: out_valid=0, Y=0, zero=0, out_count=0, both stage valids=0, FSM=IDLE, acc=0. Reset applies immediately; an in-flight burst is dropped.
//  Opcodes:
//   0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR (bitwise A,B).
//   6 ACC_AND, 7 ACC_OR (A&B combined into accumulator).
//  Handshake: transfer when valid&&ready on either side.
//   in_ready = !s1_valid || s1 advancing. s1 advances when s2 is empty or out_ready=1.
//   in_ready may depend combinationally on out_ready.
//   out_valid stays high and Y/zero/out_count stay stable until out_ready=1.
//  Latency: result is on Y 2 cycles after acceptance when out_ready is held high. Throughput is 1 beat/cycle.
//  Stage1 registers op result, zero, count and last flag. Stage2 is the output register.
//  FSM (registered in stage1 domain): IDLE, ACCUM.
//   IDLE + acc op + !in_last:
//    acc <= identity op (A&B). Identity is all-ones for ACC_AND, zero for ACC_OR.
//    cnt <= 1; op latched; no output produced; -> ACCUM.
//   IDLE + acc op + in_last: single-beat burst. Emit A&B, count 1; stay IDLE.
//   ACCUM + beat: acc <= acc OP_latched (A&B), using the latched op. cnt++ (saturating).
//    The op input is ignored in ACCUM, including non-acc codes.
//   ACCUM + beat + in_last: emit combined value and cnt. -> IDLE.
//   Non-last accumulate beats are accepted (in_ready obeys the same rule) but never produce out_valid.
//  Width rules: all ops are WIDTH bits; no carry. zero = ~|Y.
//  Counter saturates at 2**CNT_W-1; there is no wrap.
//  Simultaneous output pop and input push in the same cycle: both complete, no bubble.
// CONFIGURATION
//  LOGIC_UNIT_PARITY_EN defined:
//   Adds output port parity (1 bit) = ^Y, registered with Y. Reset value 0.
//   It is stable under backpressure like Y.
//  Undefined: parity port and its logic are absent; all other behaviour is identical.
// STRUCTURE
//  logic_unit_pkg holds:
//   op code localparams/enum (OP_AND..OP_ACC_OR);
//   FSM state typedef (ST_IDLE, ST_ACCUM);
//   function acc_identity(op).
//  Sub-module logic_unit_stage: one valid/ready register slice, parametrised payload width.
//   It is instantiated twice; the top adds the op decode, FSM and accumulator.
// TESTING
//  1 Basic ops: WIDTH=8, A=8'hC3, B=8'h5A, ops 0..5, out_ready=1.
//    -> Y = 42,DB,99,BD,24,66 respectively; each 2 cycles after accept; count=1.
//  2 Zero flag: AND with A=8'hF0, B=8'h0F -> Y=0, zero=1. OR of the same -> Y=FF, zero=0.
//  3 Accumulate: ACC_AND 3 beats (A=B): FF, F7, 7F, last on beat 3.
//    -> single output Y=8'h77, count=3. No out_valid on beats 1-2.
//    ACC_OR with A=B: 01, 02, last 80 -> Y=8'h83.
//  4 Backpressure: stream 6 XOR beats with out_ready=0 for 5 cycles.
//    -> in_ready drops after 2 beats held; Y stable.
//    On release, all 6 results emerge in order with none lost or duplicated.
//  5 Reset mid-burst: assert rst_n=0 after 2 ACC_OR beats.
//    -> outputs 0 immediately; next burst starts from the identity value with count 1.
//  6 Saturation and parity: CNT_W=2, 5-beat ACC_OR burst -> count=3.
//    With LOGIC_UNIT_PARITY_EN: Y=8'h07 -> parity=1.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: opcodes, FSM states and accumulate identity shared by the logic unit files.
package logic_unit_pkg;
  typedef enum logic [2:0] {
    OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR, OP_ACC_AND, OP_ACC_OR
  } op_e;
  typedef enum logic {ST_IDLE, ST_ACCUM} state_e;
  function automatic logic acc_identity(op_e op);
    return op == OP_ACC_AND;
  endfunction
endpackage

// File: rtl/logic_unit_if.sv
// logic_unit_if: valid/ready operand and result bus; LOGIC_UNIT_PARITY_EN adds the parity signal.
interface logic_unit_if #(parameter int WIDTH = 8, parameter int CNT_W = 4);
  logic in_valid, in_ready, in_last, out_valid, out_ready, zero;
  logic [2:0] op;
  logic [WIDTH-1:0] A, B, Y;
  logic [CNT_W-1:0] out_count;
`ifdef LOGIC_UNIT_PARITY_EN
  logic parity;
`endif
  modport master (
    output in_valid, op, A, B, in_last, out_ready,
    input in_ready, out_valid, Y, zero, out_count
`ifdef LOGIC_UNIT_PARITY_EN
    , input parity
`endif
  );
  modport slave (
    input in_valid, op, A, B, in_last, out_ready,
    output in_ready, out_valid, Y, zero, out_count
`ifdef LOGIC_UNIT_PARITY_EN
    , output parity
`endif
  );
endinterface

// File: rtl/logic_unit_stage.sv
// logic_unit_stage: one valid/ready register slice with a parametrised payload.
module logic_unit_stage #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage bitwise logic unit with AND/OR burst accumulate.
// LOGIC_UNIT_PARITY_EN adds a registered parity output (^Y).
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic clk,
  input logic rst_n,
  logic_unit_if.slave bus
);
`ifdef LOGIC_UNIT_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int W2 = CNT_W + 1 + PW + WIDTH;
  state_e state;
  op_e op, acc_op;
  logic [WIDTH-1:0] acc, ab, seed, merged, bit_res, res;
  logic [CNT_W-1:0] cnt, cnt_inc, res_cnt;
  logic is_acc, emit, fire, s1_valid, s2_ready;
  logic [W2:0] s1_d, s1_q;
  logic [W2-1:0] s2_q;
  assign op = op_e'(bus.op);
  assign fire = bus.in_valid && bus.in_ready;
  always_comb begin
    ab = bus.A & bus.B;
    is_acc = op == OP_ACC_AND || op == OP_ACC_OR;
    seed = op == OP_ACC_AND ? {WIDTH{acc_identity(op)}} & ab : {WIDTH{acc_identity(op)}} | ab;
    merged = acc_op == OP_ACC_AND ? acc & ab : acc | ab;
    cnt_inc = &cnt ? cnt : cnt + CNT_W'(1);
    bit_res = op == OP_AND  ? ab :
              op == OP_OR   ? bus.A | bus.B :
              op == OP_XOR  ? bus.A ^ bus.B :
              op == OP_NAND ? ~ab :
              op == OP_NOR  ? ~(bus.A | bus.B) : ~(bus.A ^ bus.B);
    res = state == ST_ACCUM ? merged : is_acc ? seed : bit_res;
    res_cnt = state == ST_ACCUM ? cnt_inc : CNT_W'(1);
    emit = !(state == ST_ACCUM || is_acc) || bus.in_last;
  end
  // Accumulator and burst state advance only on accepted beats; the op input is ignored mid-burst.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      acc <= '0;
      cnt <= '0;
      acc_op <= OP_ACC_AND;
    end else if (fire) begin
      if (state == ST_IDLE && is_acc && !bus.in_last) begin
        state <= ST_ACCUM;
        acc <= seed;
        cnt <= CNT_W'(1);
        acc_op <= op;
      end else if (state == ST_ACCUM) begin
        acc <= merged;
        cnt <= cnt_inc;
        if (bus.in_last) state <= ST_IDLE;
      end
    end
`ifdef LOGIC_UNIT_PARITY_EN
  assign s1_d = {emit, res_cnt, ~|res, ^res, res};
  assign {bus.out_count, bus.zero, bus.parity, bus.Y} = s2_q;
`else
  assign s1_d = {emit, res_cnt, ~|res, res};
  assign {bus.out_count, bus.zero, bus.Y} = s2_q;
`endif
  // Every accepted beat occupies stage 1; only emitting beats are passed on to the output stage.
  logic_unit_stage #(.W(W2 + 1)) u_s1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(bus.in_valid), .in_ready(bus.in_ready), .in_data(s1_d),
    .out_valid(s1_valid), .out_ready(s2_ready), .out_data(s1_q)
  );
  logic_unit_stage #(.W(W2)) u_s2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s1_valid && s1_q[W2]), .in_ready(s2_ready), .in_data(s1_q[W2-1:0]),
    .out_valid(bus.out_valid), .out_ready(bus.out_ready), .out_data(s2_q)
  );
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: randomized self-checking bench for logic_unit_pipe against a queue-based reference.
module tb_logic_unit_pipe;
  logic clk = 1'b0, rst_n = 1'b0;
  int errors = 0, checks = 0, cyc = 0, acc_t = 0;
  logic rand_bp = 1'b0;
  typedef struct {logic [7:0] y; logic z; logic [3:0] c; logic p; int t;} obs_t;
  typedef struct {logic [7:0] y; logic [3:0] c;} exp_t;
  obs_t got[$];
  exp_t exp_q[$];
  logic_unit_if #(.WIDTH(8), .CNT_W(4)) bus ();
  logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  logic dut_par;
`ifdef LOGIC_UNIT_PARITY_EN
  assign dut_par = bus.parity;
`else
  assign dut_par = 1'b0;
`endif
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && bus.out_valid && bus.out_ready)
      got.push_back(obs_t'{bus.Y, bus.zero, bus.out_count, dut_par, cyc});
  end
  always @(negedge clk) if (rand_bp) bus.out_ready = $urandom_range(0, 3) != 0;

  function automatic logic [7:0] ref_op(int op, logic [7:0] a, logic [7:0] b);
    case (op)
      0: return a & b;
      1: return a | b;
      2: return a ^ b;
      3: return ~(a & b);
      4: return ~(a | b);
      default: return ~(a ^ b);
    endcase
  endfunction

  task automatic send(input int op, input logic [7:0] a, input logic [7:0] b, input logic last);
    int n = 0;
    bus.in_valid = 1'b1; bus.op = 3'(op); bus.A = a; bus.B = b; bus.in_last = last;
    #1;
    while (!bus.in_ready && n < 200) begin @(negedge clk); #1; n++; end
    checks++;
    if (!bus.in_ready) begin errors++; $display("FAIL send_timeout op=%0d in_ready=%b required 1", op, bus.in_ready); end
    acc_t = cyc;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_got(input int n, output bit ok);
    int k = 0;
    while (got.size() < n && k < 300) begin @(negedge clk); k++; end
    ok = got.size() >= n;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.Y !== 8'h00) begin errors++; $display("FAIL reset_Y got=%h exp=00", bus.Y); end
    checks++; if (bus.zero !== 1'b0) begin errors++; $display("FAIL reset_zero got=%b exp=0", bus.zero); end
    checks++; if (bus.out_count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.out_count); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (dut_par !== 1'b0) begin errors++; $display("FAIL reset_parity got=%b exp=0", dut_par); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_ops;
    logic [7:0] tbl [6] = '{8'h42, 8'hDB, 8'h99, 8'hBD, 8'h24, 8'h66};
    bit ok;
    for (int op = 0; op < 6; op++) begin
      got.delete();
      send(op, 8'hC3, 8'h5A, 1'b0);
      wait_got(1, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL basic_timeout op=%0d results=%0d exp=1", op, got.size()); end
      else begin
        checks++; if (got[0].y !== tbl[op]) begin errors++; $display("FAIL basic_Y op=%0d got=%h exp=%h", op, got[0].y, tbl[op]); end
        checks++; if (got[0].c !== 4'd1) begin errors++; $display("FAIL basic_count op=%0d got=%0d exp=1", op, got[0].c); end
        checks++; if (got[0].z !== 1'b0) begin errors++; $display("FAIL basic_zero op=%0d got=%b exp=0", op, got[0].z); end
        checks++; if (got[0].t - acc_t !== 2) begin errors++; $display("FAIL basic_latency op=%0d got=%0d exp=2", op, got[0].t - acc_t); end
`ifdef LOGIC_UNIT_PARITY_EN
        checks++; if (got[0].p !== ^tbl[op]) begin errors++; $display("FAIL basic_parity op=%0d got=%b exp=%b", op, got[0].p, ^tbl[op]); end
`endif
      end
    end
  endtask

  task automatic test_zero;
    bit ok;
    got.delete();
    send(0, 8'hF0, 8'h0F, 1'b0);
    send(1, 8'hF0, 8'h0F, 1'b0);
    wait_got(2, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL zero_timeout results=%0d exp=2", got.size()); end
    else begin
      checks++; if (got[0].y !== 8'h00 || got[0].z !== 1'b1) begin errors++; $display("FAIL zero_and got=%h/%b exp=00/1", got[0].y, got[0].z); end
      checks++; if (got[1].y !== 8'hFF || got[1].z !== 1'b0) begin errors++; $display("FAIL zero_or got=%h/%b exp=FF/0", got[1].y, got[1].z); end
    end
  endtask

  task automatic test_accum;
    bit ok;
    got.delete();
    send(6, 8'hFF, 8'hFF, 1'b0);
    send(6, 8'hF7, 8'hF7, 1'b0);
    repeat (4) @(negedge clk);
    checks++; if (got.size() != 0) begin errors++; $display("FAIL acc_early_output results=%0d exp=0", got.size()); end
    send(6, 8'h7F, 8'h7F, 1'b1);
    send(7, 8'h01, 8'h01, 1'b0);
    send(7, 8'h02, 8'h02, 1'b0);
    send(7, 8'h80, 8'h80, 1'b1);
    wait_got(2, ok);
    checks++;
    if (!ok || got.size() != 2) begin errors++; $display("FAIL acc_results got=%0d exp=2", got.size()); end
    else begin
      checks++; if (got[0].y !== 8'h77 || got[0].c !== 4'd3) begin errors++; $display("FAIL acc_and got=%h/%0d exp=77/3", got[0].y, got[0].c); end
      checks++; if (got[1].y !== 8'h83 || got[1].c !== 4'd3) begin errors++; $display("FAIL acc_or got=%h/%0d exp=83/3", got[1].y, got[1].c); end
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] a [6], b [6], y_hold;
    int i = 0, guard = 0;
    bit ok, held = 0, rdy;
    got.delete();
    for (int k = 0; k < 6; k++) begin a[k] = 8'($urandom); b[k] = 8'($urandom); end
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1; bus.op = 3'd2; bus.A = a[i]; bus.B = b[i]; bus.in_last = 1'b0;
      #1;
      rdy = bus.in_ready;
      if (bus.out_valid && !held) begin held = 1; y_hold = bus.Y; end
      @(posedge clk);
      if (rdy) i++;
      @(negedge clk);
    end
    #1;
    checks++; if (i != 2) begin errors++; $display("FAIL bp_accepted got=%0d exp=2", i); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b exp=0", bus.in_ready); end
    checks++; if (!held || bus.out_valid !== 1'b1 || bus.Y !== y_hold) begin errors++; $display("FAIL bp_Y_stable got=%h exp=%h", bus.Y, y_hold); end
    checks++; if (bus.Y !== (a[0] ^ b[0])) begin errors++; $display("FAIL bp_head got=%h exp=%h", bus.Y, a[0] ^ b[0]); end
    bus.out_ready = 1'b1;
    while (i < 6 && guard < 100) begin
      bus.A = a[i]; bus.B = b[i];
      #1;
      rdy = bus.in_ready;
      @(posedge clk);
      if (rdy) i++;
      @(negedge clk);
      guard++;
    end
    bus.in_valid = 1'b0;
    wait_got(6, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (got.size() != 6) begin errors++; $display("FAIL bp_count got=%0d exp=6", got.size()); end
    else for (int k = 0; k < 6; k++) begin
      checks++; if (got[k].y !== (a[k] ^ b[k]) || got[k].c !== 4'd1) begin errors++; $display("FAIL bp_order k=%0d got=%h exp=%h", k, got[k].y, a[k] ^ b[k]); end
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    got.delete(); exp_q.delete();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      int op = $urandom_range(0, 5);
      logic [7:0] a = 8'($urandom), b = 8'($urandom);
      exp_q.push_back(exp_t'{ref_op(op, a, b), 4'd1});
      send(op, a, b, 1'($urandom));
      if (k < 15) begin
        bus.in_valid = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    wait_got(16, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_count got=%0d exp=16", got.size()); end
    else for (int k = 0; k < 16; k++) begin
      checks++; if (got[k].y !== exp_q[k].y || got[k].c !== exp_q[k].c || got[k].z !== (exp_q[k].y == 0)) begin errors++; $display("FAIL b2b_data k=%0d got=%h exp=%h", k, got[k].y, exp_q[k].y); end
      checks++; if (got[k].t !== got[0].t + k) begin errors++; $display("FAIL b2b_bubble k=%0d got_cycle=%0d exp=%0d", k, got[k].t, got[0].t + k); end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    got.delete();
    send(7, 8'h0F, 8'hFF, 1'b0);
    send(7, 8'hF0, 8'hF0, 1'b0);
    send(0, 8'h55, 8'h55, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.Y !== 8'h00 || bus.out_count !== 4'd0 || bus.zero !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs got=%b/%h/%0d/%b exp=0/00/0/0", bus.out_valid, bus.Y, bus.out_count, bus.zero); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    got.delete();
    send(7, 8'h10, 8'h10, 1'b0);
    send(7, 8'h20, 8'h20, 1'b1);
    wait_got(1, ok);
    repeat (2) @(negedge clk);
    checks++;
    if (got.size() != 1) begin errors++; $display("FAIL rst_mid_results got=%0d exp=1", got.size()); end
    else begin
      checks++; if (got[0].y !== 8'h30 || got[0].c !== 4'd2) begin errors++; $display("FAIL rst_mid_burst got=%h/%0d exp=30/2", got[0].y, got[0].c); end
    end
  endtask

  task automatic test_saturation;
    logic [7:0] y = 8'h00, v;
    bit ok;
    got.delete();
    for (int k = 0; k < 18; k++) begin
      v = 8'($urandom) & 8'($urandom);
      y |= v;
      send(k == 0 ? 7 : $urandom_range(0, 7), v, 8'hFF, k == 17);
    end
    send(7, 8'h01, 8'h01, 1'b0);
    send(7, 8'h02, 8'h02, 1'b0);
    send(7, 8'h04, 8'h04, 1'b1);
    wait_got(2, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL sat_results got=%0d exp=2", got.size()); end
    else begin
      checks++; if (got[0].y !== y || got[0].c !== 4'd15) begin errors++; $display("FAIL sat_count got=%h/%0d exp=%h/15", got[0].y, got[0].c, y); end
      checks++; if (got[1].y !== 8'h07 || got[1].c !== 4'd3) begin errors++; $display("FAIL sat_small got=%h/%0d exp=07/3", got[1].y, got[1].c); end
`ifdef LOGIC_UNIT_PARITY_EN
      checks++; if (got[1].p !== 1'b1) begin errors++; $display("FAIL parity_07 got=%b exp=1", got[1].p); end
      checks++; if (got[0].p !== ^y) begin errors++; $display("FAIL parity_sat got=%b exp=%b", got[0].p, ^y); end
`endif
    end
  endtask

  task automatic test_random;
    bit ok;
    got.delete(); exp_q.delete();
    rand_bp = 1'b1;
    for (int t = 0; t < 30; t++) begin
      int op = $urandom_range(0, 7);
      logic [7:0] a = 8'($urandom), b = 8'($urandom);
      if (op < 6) begin
        exp_q.push_back(exp_t'{ref_op(op, a, b), 4'd1});
        send(op, a, b, 1'($urandom));
      end else begin
        int len = $urandom_range(1, 5);
        logic [7:0] y = a & b;
        send(op, a, b, len == 1);
        for (int k = 1; k < len; k++) begin
          a = 8'($urandom); b = 8'($urandom);
          y = op == 6 ? y & (a & b) : y | (a & b);
          send($urandom_range(0, 7), a, b, k == len - 1);
        end
        exp_q.push_back(exp_t'{y, 4'(len)});
      end
    end
    rand_bp = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    wait_got(exp_q.size(), ok);
    checks++;
    if (got.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got=%0d exp=%0d", got.size(), exp_q.size()); end
    else for (int k = 0; k < exp_q.size(); k++) begin
      checks++; if (got[k].y !== exp_q[k].y || got[k].c !== exp_q[k].c || got[k].z !== (exp_q[k].y == 0)) begin errors++; $display("FAIL rand_data k=%0d got=%h/%0d exp=%h/%0d", k, got[k].y, got[k].c, exp_q[k].y, exp_q[k].c); end
`ifdef LOGIC_UNIT_PARITY_EN
      checks++; if (got[k].p !== ^exp_q[k].y) begin errors++; $display("FAIL rand_parity k=%0d got=%b exp=%b", k, got[k].p, ^exp_q[k].y); end
`endif
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.op = 3'd0; bus.A = 8'h00; bus.B = 8'h00; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    test_reset;
    test_basic_ops;
    test_zero;
    test_accum;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    test_saturation;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
